// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/hierarchy_full_adder.sv
// One-bit full adder built from two half adders and an OR gate.
module hierarchy_full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    logic s1;
    logic c1;
    logic c2;

    // First half adder: a + b
    assign s1    = a ^ b;
    assign c1    = a & b;

    // Second half adder: partial sum + carry-in, then merge the carries
    assign sum   = s1 ^ c;
    assign c2    = s1 & c;
    assign carry = c1 | c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder controller: one full adder cell is reused for
// every bit position, LSB first, with the carry held in a flop.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned   CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  sr;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          s;
    logic          co;
    logic [W-1:0]  b_load;
    logic          c_load;

    hierarchy_full_adder u_fa (
        .a     (op_a[0]),
        .b     (op_b[0]),
        .c     (carry),
        .sum   (s),
        .carry (co)
    );

    // Operand B and initial carry as loaded on start (two's-complement subtract when enabled)
    always_comb begin
        b_load = b;
        c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load = ~b;
            c_load = 1'b1;
        end
`endif
    end

    // Controller FSM with shift registers, bit counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sr    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sr    <= {s, sr[W-1:1]};
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= {s, sr[W-1:1]};
                        cout  <= co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (W=8). A cycle-level result
// model predicts busy/done/sum/cout; directed vectors pin the model.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int tests;
    int fails;

    serial_adder_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a run lasts W busy cycles, then a one-cycle done with result a+b+cin
    int           rem;
    logic [W:0]   pend;
    logic [W:0]   res;
    logic         exp_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      = 0;
            pend     = '0;
            res      = '0;
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (rem > 0) begin
                rem = rem - 1;
                if (rem == 0) begin
                    res      = pend;
                    exp_done = 1'b1;
                end
            end else if (start) begin
                pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`ifdef SERIAL_ADDER_SUB_EN
                if (sub) pend = {1'b0, a} + {1'b0, ~b} + 1;
`endif
                rem = W;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(rem > 0));
        check("done", 64'(done), 64'(exp_done));
        check("result", 64'({cout, sum}), 64'(res));
    end

    task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
        @(posedge clk); #2;
        a = ta; b = tb; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
`else
        if (ts) $display("note: subtract request ignored in add-only build");
`endif
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    // Counts negedges until done; expired budget is a failure
    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cyc++;
            if (done) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: no done within 30 cycles", name);
        cyc = -1;
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        tests = 0; fails = 0;
        #23;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_result", 64'({cout, sum, done}), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Basic add with latency check
        do_start(8'h5A, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        check("busy_cycle1", 64'(busy), 64'd1);
        wait_done("add_5a_3c", cyc);
        check("latency", 64'(cyc + 1), 64'd9);
        check("sum_5a_3c", 64'({cout, sum}), 64'h096);
        repeat (3) @(negedge clk);

        do_start(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done("add_ff_01", cyc);
        check("sum_ff_01", 64'({cout, sum}), 64'h100);

        do_start(8'hFF, 8'h00, 1'b1, 1'b0);
        wait_done("add_ff_00_c", cyc);
        check("sum_ff_00_c", 64'({cout, sum}), 64'h100);

        // Start while busy is ignored
        do_start(8'h5A, 8'h3C, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        a = 8'h11; b = 8'h00; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done("ignored_start", cyc);
        check("sum_ignored", 64'({cout, sum}), 64'h096);
        repeat (12) @(negedge clk);
        check("no_second_done", 64'(busy), 64'd0);

        // Back-to-back: start held in the DONE cycle
        do_start(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_done("b2b_first", cyc);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        @(posedge clk); #2 start = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_held", 64'({cout, sum}), 64'h096);
        wait_done("b2b_second", cyc);
        check("b2b_latency", 64'(cyc), 64'd5);
        check("b2b_sum", 64'({cout, sum}), 64'h002);

        // Reset mid-operation
        do_start(8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outputs", 64'({cout, sum, done}), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_no_done", 64'({cout, sum}), 64'd0);
        do_start(8'h12, 8'h34, 1'b1, 1'b0);
        wait_done("after_reset", cyc);
        check("sum_after_reset", 64'({cout, sum}), 64'h047);

`ifdef SERIAL_ADDER_SUB_EN
        do_start(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done("sub_10_20", cyc);
        check("sub_10_20", 64'({cout, sum}), 64'h0F0);
        do_start(8'h20, 8'h10, 1'b1, 1'b1);
        wait_done("sub_20_10", cyc);
        check("sub_20_10", 64'({cout, sum}), 64'h110);
`endif

        // A few more patterns checked by the model
        do_start(8'hAA, 8'h55, 1'b1, 1'b0);
        wait_done("add_aa_55_c", cyc);
        check("sum_aa_55_c", 64'({cout, sum}), 64'h100);
        do_start(8'h80, 8'h80, 1'b0, 1'b0);
        wait_done("add_80_80", cyc);
        check("sum_80_80", 64'({cout, sum}), 64'h100);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
